bf_f_engine: RTL and testbench

- Blowfish F-function sequencer. Takes a 32-bit left half xL and returns F(xL) = ((S1[a] + S2[b]) ^ S3[c]) + S4[d], where a = xL[31:24], b = xL[23:16], c = xL[15:8], d = xL[7:0].
- Sits directly upstream of the S-box lookup blocks (the bf_loopup_s*box family). It drives their 8-bit index and consumes their 32-bit words through one shared, time-multiplexed lookup port.
- Its result is consumed by the round controller.

---
 rtl/bf_f_engine.sv | 132 +++++++++++++
 tb/tb_bf_f_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bf_f_engine.sv
// Blowfish F-function sequencer: F(x) = ((S1[a] + S2[b]) ^ S3[c]) + S4[d], one shared
// S-box lookup port stepped through S1..S4; LOOKUP_LAT selects 0- or 1-cycle S-box reads.
//
//  state | meaning
//  IDLE  | waiting for in_valid; in_ready high
//  Wn    | S-box n index presented, waiting for registered read data (LOOKUP_LAT = 1)
//  Ln    | S-box n data valid on sbox_data; fold into accumulator
//  DONE  | f_out valid; waiting for out_ready
module bf_f_engine #(
    parameter int LOOKUP_LAT = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] xl,
    output logic [1:0]  sbox_sel,
    output logic [7:0]  sbox_idx,
    input  logic [31:0] sbox_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] f_out,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        W1   = 4'd1,
        L1   = 4'd2,
        W2   = 4'd3,
        L2   = 4'd4,
        W3   = 4'd5,
        L3   = 4'd6,
        W4   = 4'd7,
        L4   = 4'd8,
        DONE = 4'd9
    } state_t;

    localparam bit HAS_WAIT = (LOOKUP_LAT == 1);

    state_t      state_q, state_d;
    logic [31:0] xr_q, xr_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] f_q, f_d;
    logic        ov_q, ov_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  idx_q, idx_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            xr_q    <= 32'd0;
            acc_q   <= 32'd0;
            f_q     <= 32'd0;
            ov_q    <= 1'b0;
            sel_q   <= 2'd0;
            idx_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            acc_q   <= acc_d;
            f_q     <= f_d;
            ov_q    <= ov_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
        end
    end

    // Index/select for the next lookup are registered on the edge that enters Wn/Ln,
    // so they are stable for the whole wait+lookup window.
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        acc_d   = acc_q;
        f_d     = f_q;
        ov_d    = ov_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xr_d    = xl;
                    sel_d   = 2'd0;
                    idx_d   = xl[31:24];
                    state_d = HAS_WAIT ? W1 : L1;
                end
            end
            W1: state_d = L1;
            L1: begin
                acc_d   = sbox_data;
                sel_d   = 2'd1;
                idx_d   = xr_q[23:16];
                state_d = HAS_WAIT ? W2 : L2;
            end
            W2: state_d = L2;
            L2: begin
                acc_d   = acc_q + sbox_data;
                sel_d   = 2'd2;
                idx_d   = xr_q[15:8];
                state_d = HAS_WAIT ? W3 : L3;
            end
            W3: state_d = L3;
            L3: begin
                acc_d   = acc_q ^ sbox_data;
                sel_d   = 2'd3;
                idx_d   = xr_q[7:0];
                state_d = HAS_WAIT ? W4 : L4;
            end
            W4: state_d = L4;
            L4: begin
                f_d     = acc_q + sbox_data;
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = ov_q;
    assign f_out     = f_q;
    assign sbox_sel  = sel_q;
    assign sbox_idx  = idx_q;

endmodule

// File: tb/tb_bf_f_engine.sv
// Bench for bf_f_engine: one instance per LOOKUP_LAT sharing stimulus, a table-based F model,
// a negedge scoreboard for every result, plus directed latency/sequence/backpressure/reset steps.
module tb_bf_f_engine;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] xl;

    logic        in_ready0, out_valid0, busy0;
    logic [1:0]  sel0;
    logic [7:0]  idx0;
    logic [31:0] sd0, f0;
    logic        in_ready1, out_valid1, busy1;
    logic [1:0]  sel1;
    logic [7:0]  idx1;
    logic [31:0] sd1, f1;

    logic [31:0] sb [4][256];
    logic [31:0] q0[$], q1[$];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    bf_f_engine #(.LOOKUP_LAT(0)) dut0 (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .in_valid(in_valid), .in_ready(in_ready0),
        .xl(xl), .sbox_sel(sel0), .sbox_idx(idx0), .sbox_data(sd0), .out_valid(out_valid0),
        .out_ready(out_ready), .f_out(f0), .busy(busy0));

    bf_f_engine #(.LOOKUP_LAT(1)) dut1 (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .in_valid(in_valid), .in_ready(in_ready1),
        .xl(xl), .sbox_sel(sel1), .sbox_idx(idx1), .sbox_data(sd1), .out_valid(out_valid1),
        .out_ready(out_ready), .f_out(f1), .busy(busy1));

    // S-box models: combinational for dut0, one-cycle registered read for dut1
    assign sd0 = sb[sel0][idx0];
    always @(posedge wb_clk_i) sd1 <= sb[sel1][idx1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] f_ref(input logic [31:0] x);
        return ((sb[0][x[31:24]] + sb[1][x[23:16]]) ^ sb[2][x[15:8]]) + sb[3][x[7:0]];
    endfunction

    task automatic fill_tables();
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 256; i++) sb[s][i] = $urandom;
        sb[0][0] = 32'hd1310ba6;
        sb[1][0] = 32'h4b7a70e9;
        sb[2][0] = 32'he93d5a68;
        sb[3][0] = 32'h3a39ce37;
    endtask

    // Scoreboard: sample handshakes mid-cycle, ahead of the edge that commits them
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            q0.delete();
            q1.delete();
        end else begin
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) check("sb0_unexpected_out", 32'(q0.size()), 32'd1);
                else check("sb0_f_out", f0, q0.pop_front());
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) check("sb1_unexpected_out", 32'(q1.size()), 32'd1);
                else check("sb1_f_out", f1, q1.pop_front());
            end
            if (in_valid && in_ready0) q0.push_back(f_ref(xl));
            if (in_valid && in_ready1) q1.push_back(f_ref(xl));
        end
    end

    // One operation with out_ready high; returns cycles from accept cycle to first out_valid
    task automatic timed_op(input logic [31:0] x, output int l0, output int l1,
                            output logic [31:0] r0, output logic [31:0] r1);
        l0 = 0; l1 = 0; r0 = 32'd0; r1 = 32'd0;
        xl = x;
        in_valid = 1'b1;
        @(posedge wb_clk_i) #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 20 && (l0 == 0 || l1 == 0); n++) begin
            if (out_valid0 && l0 == 0) begin l0 = n; r0 = f0; end
            if (out_valid1 && l1 == 0) begin l1 = n; r1 = f1; end
            @(posedge wb_clk_i) #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 50 && !(in_ready0 && in_ready1); n++) @(posedge wb_clk_i) #1;
        check(tag, 32'({in_ready0, in_ready1}), 32'd3);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctl0"}, 32'({in_ready0, out_valid0, busy0, sel0, idx0}), 32'h1000);
        check({tag, "_ctl1"}, 32'({in_ready1, out_valid1, busy1, sel1, idx1}), 32'h1000);
        check({tag, "_f0"}, f0, 32'd0);
        check({tag, "_f1"}, f1, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          l0, l1;
        logic [31:0] r0, r1, x, exp;
        int          prev0, prev1;
        int          rise0[$], rise1[$];

        wb_rst_i = 1'b1; in_valid = 1'b0; out_ready = 1'b1; xl = 32'd0;
        fill_tables();
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        check_reset_state("reset");

        // Standard S-box first words, xl = 0
        timed_op(32'h0, l0, l1, r0, r1);
        check("std_f0", r0, 32'h2fcff51e);
        check("std_f1", r1, 32'h2fcff51e);
        check("std_lat0", 32'(l0), 32'd5);
        check("std_lat1", 32'(l1), 32'd9);
        wait_idle("idle_after_std");

        // Lookup sequence; registered S-box holds each pair for two cycles
        x = 32'h01234567;
        xl = x; in_valid = 1'b1;
        @(posedge wb_clk_i) #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i <= 4)
                check($sformatf("seq0_%0d", i), 32'({sel0, idx0}),
                      32'({2'(i - 1), 8'((x >> (8 * (4 - i))) & 32'hff)}));
            check($sformatf("seq1_%0d", i), 32'({sel1, idx1}),
                  32'({2'((i - 1) / 2), 8'((x >> (8 * (3 - (i - 1) / 2))) & 32'hff)}));
            @(posedge wb_clk_i) #1;
        end
        wait_idle("idle_after_seq");

        // Constant tables exercise both modular wraps
        for (int i = 0; i < 256; i++) begin
            sb[0][i] = 32'hffffffff; sb[1][i] = 32'h2; sb[2][i] = 32'h0; sb[3][i] = 32'hffffffff;
        end
        timed_op($urandom, l0, l1, r0, r1);
        check("wrap_f0", r0, 32'h0);
        check("wrap_f1", r1, 32'h0);
        check("wrap_lat0", 32'(l0), 32'd5);
        check("wrap_lat1", 32'(l1), 32'd9);
        fill_tables();
        wait_idle("idle_after_wrap");

        // Backpressure: results held, new requests ignored
        out_ready = 1'b0;
        x = $urandom;
        exp = f_ref(x);
        xl = x; in_valid = 1'b1;
        @(posedge wb_clk_i) #1;
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !(out_valid0 && out_valid1); n++) @(posedge wb_clk_i) #1;
        in_valid = 1'b1;
        xl = ~x;
        for (int i = 0; i < 7; i++) begin
            check("bp_ctl", 32'({out_valid0, in_ready0, out_valid1, in_ready1}), 32'hA);
            check("bp_f0", f0, exp);
            check("bp_f1", f1, exp);
            @(posedge wb_clk_i) #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge wb_clk_i) #1;
        check("bp_release", 32'({out_valid0, in_ready0, out_valid1, in_ready1}), 32'h5);
        check("bp_f_kept", f0, exp);

        // Reset pulse while dut0 is in L3
        xl = $urandom; in_valid = 1'b1;
        @(posedge wb_clk_i) #1;
        in_valid = 1'b0;
        repeat (2) @(posedge wb_clk_i) #1;
        check("l3_sel0", 32'(sel0), 32'd2);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i) #1;
        wb_rst_i = 1'b0;
        check_reset_state("midrst");
        timed_op(32'h0, l0, l1, r0, r1);
        check("post_rst_f0", r0, 32'h2fcff51e);
        check("post_rst_f1", r1, 32'h2fcff51e);
        check("post_rst_lat1", 32'(l1), 32'd9);
        wait_idle("idle_after_rst");

        // Random traffic with random backpressure; scoreboard checks every result
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            xl        = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge wb_clk_i) #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge wb_clk_i) #1;
        check("drain0", 32'(q0.size()), 32'd0);
        check("drain1", 32'(q1.size()), 32'd0);

        // Back-to-back throughput
        prev0 = 0; prev1 = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            xl = $urandom;
            @(posedge wb_clk_i) #1;
            if (out_valid0 && prev0 == 0) rise0.push_back(c);
            if (out_valid1 && prev1 == 0) rise1.push_back(c);
            prev0 = int'(out_valid0);
            prev1 = int'(out_valid1);
        end
        in_valid = 1'b0;
        check("tp0_count", 32'(rise0.size() >= 4), 32'd1);
        check("tp1_count", 32'(rise1.size() >= 4), 32'd1);
        for (int i = 0; i < 3 && i + 1 < rise0.size(); i++)
            check("tp0_period", 32'(rise0[i + 1] - rise0[i]), 32'd6);
        for (int i = 0; i < 3 && i + 1 < rise1.size(); i++)
            check("tp1_period", 32'(rise1[i + 1] - rise1[i]), 32'd10);
        repeat (15) @(posedge wb_clk_i) #1;
        check("final_drain0", 32'(q0.size()), 32'd0);
        check("final_drain1", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
